// File: rtl/hall_period_meter.sv
// Hall-sensor commutation period meter: synchronizes the hall lines, rejects glitch and invalid edges, and reports the period.
// Optional macro HALL_AVG4_EN replaces the raw period with a four-period running average.
module hall_period_meter #(
  parameter int DATA_WIDTH = 16,
  parameter int MIN_PERIOD = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            hall,
  output logic [DATA_WIDTH-1:0] period_speed,
  output logic                  period_valid,
  output logic                  stalled,
  output logic                  hall_fault
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] MIN_P   = DATA_WIDTH'(MIN_PERIOD);
  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

  logic [2:0]            s1, s2, s3;
  logic [DATA_WIDTH-1:0] cnt;
  logic                  armed;
  logic                  hall_edge;
  logic                  accept;
  logic                  cnt_sat;
  logic [DATA_WIDTH-1:0] new_period;

  function automatic logic state_ok(input logic [2:0] s);
    return (s != 3'b000) && (s != 3'b111);
  endfunction

  always_comb begin
    hall_edge = (s2 != s3);
    accept    = hall_edge && state_ok(s2) && state_ok(s3) && ((cnt >= MIN_P) || !armed);
    cnt_sat   = (cnt == CNT_MAX);
  end

`ifdef HALL_AVG4_EN
  logic [DATA_WIDTH-1:0] hist [3];
  logic [1:0]            n_hist;

  function automatic logic [DATA_WIDTH-1:0] avg4(input logic [DATA_WIDTH-1:0] a, b, c, d);
    logic [DATA_WIDTH+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return sum[DATA_WIDTH+1:2];
  endfunction

  // The current period counts as the fourth one once three are held.
  always_comb begin
    new_period = cnt;
    if (n_hist == 2'd3)
      new_period = avg4(hist[0], hist[1], hist[2], cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_hist <= 2'd0;
    end else if (accept && armed) begin
      if (n_hist != 2'd3)
        n_hist <= n_hist + 2'd1;
    end else if (!accept && cnt_sat) begin
      n_hist <= 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && armed) begin
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= cnt;
    end
  end
`else
  always_comb new_period = cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1           <= 3'b000;
      s2           <= 3'b000;
      s3           <= 3'b000;
      cnt          <= '0;
      armed        <= 1'b0;
      period_speed <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      hall_fault   <= 1'b0;
    end else begin
      s1           <= hall;
      s2           <= s1;
      s3           <= s2;
      hall_fault   <= !state_ok(s2);
      period_valid <= 1'b0;
      // An accepted edge beats saturation in the same cycle.
      if (accept) begin
        cnt     <= ONE;
        armed   <= 1'b1;
        stalled <= 1'b0;
        if (armed) begin
          period_speed <= new_period;
          period_valid <= 1'b1;
        end
      end else if (cnt_sat) begin
        stalled      <= 1'b1;
        period_speed <= CNT_MAX;
        armed        <= 1'b0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_hall_period_meter.sv
// Scoreboard bench for hall_period_meter: stimulus queues expected period and arrival cycle, a monitor checks each pulse.
module tb_hall_period_meter;

  localparam int DW = 16;

  logic          clk;
  logic          reset_n;
  logic [2:0]    hall;
  logic [DW-1:0] period_speed;
  logic          period_valid;
  logic          stalled;
  logic          hall_fault;

  hall_period_meter #(.DATA_WIDTH(DW), .MIN_PERIOD(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hall         (hall),
    .period_speed (period_speed),
    .period_valid (period_valid),
    .stalled      (stalled),
    .hall_fault   (hall_fault)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge_after(input int n, input logic [2:0] v);
    repeat (n) @(negedge clk);
    hall = v;
  endtask

  // Pulse is due three rising edges after the hall change made at this negedge.
  task automatic expect_pulse(input int val);
    exp_t e;
    e.val = val;
    e.due = cyc + 3;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && period_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: period_speed=%0d at cycle %0d, required no pulse", period_speed, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("period_speed", int'(period_speed), mon_e.val);
        chk("pulse_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    hall    = 3'b101;
    idle(3);
    chk("rst_period_speed", int'(period_speed), 0);
    chk("rst_period_valid", int'(period_valid), 0);
    chk("rst_stalled", int'(stalled), 0);
    chk("rst_hall_fault", int'(hall_fault), 0);
    reset_n = 1'b1;
    idle(20);
    chk("idle_hall_fault", int'(hall_fault), 0);
    chk("idle_stalled", int'(stalled), 0);

    // Basic sequence: first edge arms only.
    edge_after(1, 3'b100);
    edge_after(1000, 3'b110); expect_pulse(1000);
    edge_after(1000, 3'b010); expect_pulse(1000);

    // Glitch 20 cycles after an edge is dropped.
    edge_after(1000, 3'b011); expect_pulse(1000);
    edge_after(20, 3'b001);
    edge_after(980, 3'b101);  expect_pulse(1000);

    // Stall after a full counter range without an edge.
    idle(65530);
    chk("stall_not_yet", int'(stalled), 0);
    idle(70);
    chk("stall_set", int'(stalled), 1);
    chk("stall_period", int'(period_speed), 65535);
    edge_after(1, 3'b100);
    idle(5);
    chk("stall_cleared", int'(stalled), 0);
    chk("stall_period_held", int'(period_speed), 65535);
    edge_after(495, 3'b110);  expect_pulse(500);

    // Invalid hall states raise the fault and produce no pulse.
    idle(100);
    edge_after(1, 3'b111);
    idle(3);
    chk("fault_set", int'(hall_fault), 1);
    idle(50);
    edge_after(1, 3'b101);
    idle(5);
    chk("fault_cleared", int'(hall_fault), 0);
    edge_after(1000, 3'b100); expect_pulse(1160);

    // MIN_PERIOD boundary: 63 rejected, 64 accepted.
    edge_after(63, 3'b110);
    edge_after(1, 3'b010);    expect_pulse(64);

    // Asynchronous reset mid-count.
    idle(300);
    #5 reset_n = 1'b0;
    #1;
    chk("async_period_speed", int'(period_speed), 0);
    chk("async_period_valid", int'(period_valid), 0);
    chk("async_stalled", int'(stalled), 0);
    chk("async_hall_fault", int'(hall_fault), 0);
    idle(3);
    reset_n = 1'b1;
    idle(20);
    edge_after(1, 3'b011);
    edge_after(1000, 3'b001); expect_pulse(1000);
    edge_after(1000, 3'b101); expect_pulse(1000);
    edge_after(1000, 3'b100); expect_pulse(1000);
`ifdef HALL_AVG4_EN
    edge_after(2000, 3'b110); expect_pulse(1250);
`else
    edge_after(2000, 3'b110); expect_pulse(2000);
`endif
    idle(20);
    chk("pending_pulses", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
